// File: rtl/pll_ctrl_pkg.sv
// Shared types and default limits for the video PLL reset sequencer.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        RESET     = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    localparam int unsigned DEF_RESET_CYCLES  = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT  = 65536;
    localparam int unsigned DEF_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_MAX_RETRIES   = 3;
    localparam int unsigned LOST_W            = 8;

    // Counter width able to hold the value `limit` itself.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return int'($clog2(limit)) + 1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer with a configurable reset value.
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_ctrl.sv
// Reset sequencer and lock supervisor for the video PLL (refclk domain).
module pll_reset_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              restart,
    output logic              pll_rst,
    output logic              video_rst,
    output logic              ready,
    output logic              fault,
    output logic [LOST_W-1:0] lost_count
);

    localparam int unsigned RST_W = cnt_width(RESET_CYCLES);
    localparam int unsigned TMR_W = cnt_width(LOCK_TIMEOUT);
    localparam int unsigned STB_W = cnt_width(STABLE_CYCLES);
    localparam int unsigned RTY_W = cnt_width(MAX_RETRIES);

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RESET_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_LIMIT = TMR_W'(LOCK_TIMEOUT);
    localparam logic [STB_W-1:0]  STB_LIMIT = STB_W'(STABLE_CYCLES);
    localparam logic [RTY_W-1:0]  RTY_LIMIT = RTY_W'(MAX_RETRIES);
    localparam logic [LOST_W-1:0] LOST_MAX  = '1;

    state_t             r_state;
    state_t             w_next_state;
    logic [RST_W-1:0]   r_rst_cnt;
    logic [RST_W-1:0]   w_rst_cnt_nxt;
    logic [TMR_W-1:0]   r_timer;
    logic [TMR_W-1:0]   w_timer_nxt;
    logic [TMR_W-1:0]   w_timer_inc;
    logic [STB_W-1:0]   r_stable_cnt;
    logic [STB_W-1:0]   w_stable_nxt;
    logic [STB_W-1:0]   w_stable_inc;
    logic [RTY_W-1:0]   r_retry;
    logic [RTY_W-1:0]   w_retry_nxt;
    logic [RTY_W-1:0]   w_retry_inc;
    logic [LOST_W-1:0]  r_lost;
    logic [LOST_W-1:0]  w_lost_nxt;
    logic               w_locked_s;
    logic               w_timeout;

    logic               r_pll_rst;
    logic               r_video_rst;
    logic               r_ready;
    logic               r_fault;

    // PLL lock is asynchronous to refclk; only the synchronized copy is used.
    sync2 #(
        .RESET_VAL (1'b0)
    ) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .i_d   (pll_locked),
        .o_q   (w_locked_s)
    );

    assign w_timer_inc  = r_timer + TMR_W'(1);
    assign w_stable_inc = r_stable_cnt + STB_W'(1);
    assign w_retry_inc  = r_retry + RTY_W'(1);
    // Timeout fires on the cycle that would bring the timer to its limit.
    assign w_timeout    = (w_timer_inc == TMR_LIMIT);

    // Next-state and counter update logic; restart overrides everything.
    always_comb begin
        w_next_state  = r_state;
        w_rst_cnt_nxt = '0;
        w_timer_nxt   = r_timer;
        w_stable_nxt  = r_stable_cnt;
        w_retry_nxt   = r_retry;
        w_lost_nxt    = r_lost;

        if (restart) begin
            w_next_state = RESET;
            w_timer_nxt  = '0;
            w_stable_nxt = '0;
            w_retry_nxt  = '0;
        end else begin
            case (r_state)
                RESET: begin
                    if (r_rst_cnt == RST_LAST) begin
                        w_next_state = WAIT_LOCK;
                        w_timer_nxt  = '0;
                    end else begin
                        w_rst_cnt_nxt = r_rst_cnt + RST_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    w_timer_nxt = w_timer_inc;
                    if (w_timeout) begin
                        w_retry_nxt  = w_retry_inc;
                        w_next_state = (w_retry_inc == RTY_LIMIT) ? FAULT : RESET;
                    end else if (w_locked_s) begin
                        w_next_state = STABLE;
                        w_stable_nxt = '0;
                    end
                end
                STABLE: begin
                    w_timer_nxt = w_timer_inc;
                    if (w_timeout) begin
                        w_retry_nxt  = w_retry_inc;
                        w_next_state = (w_retry_inc == RTY_LIMIT) ? FAULT : RESET;
                    end else if (!w_locked_s) begin
                        w_next_state = WAIT_LOCK;
                    end else if (w_stable_inc == STB_LIMIT) begin
                        w_next_state = RUN;
                        w_retry_nxt  = '0;
                    end else begin
                        w_stable_nxt = w_stable_inc;
                    end
                end
                RUN: begin
                    if (!w_locked_s) begin
                        w_next_state = RESET;
                        if (r_lost != LOST_MAX) begin
                            w_lost_nxt = r_lost + LOST_W'(1);
                        end
                    end
                end
                FAULT: begin
                    w_next_state = FAULT;
                end
                default: begin
                    w_next_state = RESET;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RESET;
            r_rst_cnt    <= '0;
            r_timer      <= '0;
            r_stable_cnt <= '0;
            r_retry      <= '0;
            r_lost       <= '0;
        end else begin
            r_state      <= w_next_state;
            r_rst_cnt    <= w_rst_cnt_nxt;
            r_timer      <= w_timer_nxt;
            r_stable_cnt <= w_stable_nxt;
            r_retry      <= w_retry_nxt;
            r_lost       <= w_lost_nxt;
        end
    end

    // Output registers decoded from the next state so they track r_state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_pll_rst   <= 1'b1;
            r_video_rst <= 1'b1;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_pll_rst   <= (w_next_state == RESET) || (w_next_state == FAULT);
            r_video_rst <= (w_next_state != RUN);
            r_ready     <= (w_next_state == RUN);
            r_fault     <= (w_next_state == FAULT);
        end
    end

    assign pll_rst    = r_pll_rst;
    assign video_rst  = r_video_rst;
    assign ready      = r_ready;
    assign fault      = r_fault;
    assign lost_count = r_lost;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with small sequencing limits.
module tb_pll_reset_ctrl;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       video_rst;
    logic       ready;
    logic       fault;
    logic [7:0] lost_count;
    logic [11:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 refclk = ~refclk;

    assign obs = {pll_rst, video_rst, ready, fault, lost_count};

    pll_reset_ctrl #(
        .RESET_CYCLES  (4),
        .LOCK_TIMEOUT  (64),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_rst    (pll_rst),
        .video_rst  (video_rst),
        .ready      (ready),
        .fault      (fault),
        .lost_count (lost_count)
    );

    // Advance one refclk edge and settle 1 ns past it.
    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        restart    = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (obs !== 12'hC00) begin
            n_fail++;
            $display("FAIL reset_vals: got %h want %h", obs, 12'hC00);
        end
    endtask

    task automatic test_bringup();
        logic exp_run;
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_tests++;
            if (pll_rst !== (k < 4)) begin
                n_fail++;
                $display("FAIL bringup_pll_rst k=%0d: got %b want %b", k, pll_rst, (k < 4));
            end
        end
        repeat (10) tick();
        pll_locked = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            exp_run = (k == 11);
            n_tests++;
            if ({ready, video_rst, pll_rst, fault} !== {exp_run, !exp_run, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL bringup_run k=%0d: got %b want %b", k,
                         {ready, video_rst, pll_rst, fault}, {exp_run, !exp_run, 1'b0, 1'b0});
            end
        end
        n_tests++;
        if (lost_count !== 8'd0) begin
            n_fail++;
            $display("FAIL bringup_lost: got %0d want 0", lost_count);
        end
    endtask

    task automatic test_glitchy();
        restart = 1'b1;
        tick();
        restart    = 1'b0;
        pll_locked = 1'b0;
        n_tests++;
        if ({pll_rst, ready, lost_count} !== {1'b1, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL glitch_restart: got %b want %b", {pll_rst, ready, lost_count},
                     {1'b1, 1'b0, 8'd0});
        end
        repeat (4) tick();
        n_tests++;
        if (pll_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_release: got %b want 0", pll_rst);
        end
        pll_locked = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == 6) pll_locked = 1'b0;
            if (t == 9) pll_locked = 1'b1;
            n_tests++;
            if ({pll_rst, ready} !== {1'b0, (t >= 20)}) begin
                n_fail++;
                $display("FAIL glitch_seq t=%0d: got %b want %b", t, {pll_rst, ready},
                         {1'b0, (t >= 20)});
            end
        end
    endtask

    task automatic test_lock_loss();
        int highs;
        for (int i = 0; i < 3; i++) begin
            highs = 0;
            pll_locked = 1'b0;
            for (int t = 1; t <= 16; t++) begin
                tick();
                if (pll_rst === 1'b1) highs++;
                if (t == 2) begin
                    n_tests++;
                    if (ready !== 1'b1) begin
                        n_fail++;
                        $display("FAIL loss_early i=%0d: ready got %b want 1", i, ready);
                    end
                end
                if (t == 3) begin
                    n_tests++;
                    if ({ready, video_rst, lost_count} !== {1'b0, 1'b1, 8'(i + 1)}) begin
                        n_fail++;
                        $display("FAIL loss_drop i=%0d: got %b want %b", i,
                                 {ready, video_rst, lost_count}, {1'b0, 1'b1, 8'(i + 1)});
                    end
                    pll_locked = 1'b1;
                end
                if (t == 15 || t == 16) begin
                    n_tests++;
                    if (ready !== (t == 16)) begin
                        n_fail++;
                        $display("FAIL loss_relock i=%0d t=%0d: ready got %b want %b", i, t,
                                 ready, (t == 16));
                    end
                end
            end
            n_tests++;
            if (highs != 4) begin
                n_fail++;
                $display("FAIL loss_pulse i=%0d: pll_rst high %0d cycles want 4", i, highs);
            end
        end
    endtask

    task automatic test_restart_coincident();
        pll_locked = 1'b0;
        tick();
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        n_tests++;
        if ({ready, pll_rst, lost_count} !== {1'b0, 1'b1, 8'd3}) begin
            n_fail++;
            $display("FAIL restart_coinc: got %b want %b", {ready, pll_rst, lost_count},
                     {1'b0, 1'b1, 8'd3});
        end
        repeat (3) tick();
        n_tests++;
        if (lost_count !== 8'd3) begin
            n_fail++;
            $display("FAIL restart_coinc_hold: got %0d want 3", lost_count);
        end
    endtask

    task automatic test_timeout_fault();
        logic exp_rst;
        logic exp_flt;
        int   prints;
        int   bad;
        prints     = 0;
        bad        = 0;
        pll_locked = 1'b0;
        restart    = 1'b1;
        for (int t = 1; t <= 140; t++) begin
            tick();
            restart = 1'b0;
            exp_rst = (t <= 4) || (t >= 69 && t <= 72) || (t >= 137);
            exp_flt = (t >= 137);
            n_tests++;
            if ({pll_rst, fault, ready, video_rst} !== {exp_rst, exp_flt, 1'b0, 1'b1}) begin
                n_fail++;
                if (prints < 5) begin
                    prints++;
                    $display("FAIL timeout_seq t=%0d: got %b want %b", t,
                             {pll_rst, fault, ready, video_rst}, {exp_rst, exp_flt, 1'b0, 1'b1});
                end
            end
        end
        for (int t = 0; t < 1000; t++) begin
            tick();
            if ({fault, pll_rst, video_rst, ready} !== 4'b1110) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL fault_sticky: %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_restart_fault();
        pll_locked = 1'b1;
        restart    = 1'b1;
        tick();
        restart = 1'b0;
        n_tests++;
        if ({fault, pll_rst, video_rst, ready} !== 4'b0110) begin
            n_fail++;
            $display("FAIL fault_exit: got %b want 0110", {fault, pll_rst, video_rst, ready});
        end
        for (int t = 2; t <= 14; t++) begin
            tick();
            if (t == 5) begin
                n_tests++;
                if (pll_rst !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fault_exit_release: got %b want 0", pll_rst);
                end
            end
            if (t == 13 || t == 14) begin
                n_tests++;
                if ({ready, fault} !== {(t == 14), 1'b0}) begin
                    n_fail++;
                    $display("FAIL fault_exit_run t=%0d: got %b want %b", t, {ready, fault},
                             {(t == 14), 1'b0});
                end
            end
        end
    endtask

    task automatic test_async_reset();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        repeat (7) tick();
        n_tests++;
        if ({pll_rst, video_rst, ready} !== 3'b010) begin
            n_fail++;
            $display("FAIL async_pre: got %b want 010", {pll_rst, video_rst, ready});
        end
        #2;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        #1;
        n_tests++;
        if (obs !== 12'hC00) begin
            n_fail++;
            $display("FAIL async_vals: got %h want %h", obs, 12'hC00);
        end
        #2;
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_tests++;
            if (pll_rst !== (k < 4)) begin
                n_fail++;
                $display("FAIL async_seq_rst k=%0d: got %b want %b", k, pll_rst, (k < 4));
            end
        end
        pll_locked = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k >= 10) begin
                n_tests++;
                if ({ready, video_rst} !== {(k == 11), (k != 11)}) begin
                    n_fail++;
                    $display("FAIL async_seq_run k=%0d: got %b want %b", k, {ready, video_rst},
                             {(k == 11), (k != 11)});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_glitchy();
        test_lock_loss();
        test_restart_coincident();
        test_timeout_fault();
        test_restart_fault();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
